// File: rtl/fpu_conv_pkg.sv
// fpu_conv_pkg: shared types and helpers for the float-to-integer conversion path.
//   rm_e     - dynamic rounding-mode encoding (the unused codes 101..111 behave as RNE)
//   fclass_t - special-operand classification carried from S1 to S2
//   flen_f / bias_f - derive the float width and exponent bias from the field widths
package fpu_conv_pkg;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } rm_e;

   typedef struct packed {
      logic is_nan;
      logic is_inf;
      logic is_zero;
   } fclass_t;

   function automatic int flen_f(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   function automatic int bias_f(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fp_round_sat.sv
// fp_round_sat: combinational round / range-check / saturate / flag logic for a
// float-to-integer conversion. It is kept separate so a float-to-long unit can reuse it.
// Ports:
//   sign, int_part, g, s       - aligned magnitude, guard bit and sticky bit
//   pre_ovf                    - exponent already too large for INT_W bits
//   is_nan, is_inf, is_zero    - operand class
//   is_signed                  - 1 = signed target, 0 = unsigned
//   rm                         - rounding mode (rm_e encoding)
//   data, nv, nx               - integer result, invalid flag, inexact flag
module fp_round_sat
   import fpu_conv_pkg::*;
#(
   parameter int INT_W = 32
) (
   input  logic             sign,
   input  logic [INT_W-1:0] int_part,
   input  logic             g,
   input  logic             s,
   input  logic             pre_ovf,
   input  logic             is_nan,
   input  logic             is_inf,
   input  logic             is_zero,
   input  logic             is_signed,
   input  logic [2:0]       rm,
   output logic [INT_W-1:0] data,
   output logic             nv,
   output logic             nx
);

   // Largest representable magnitudes for a signed target, in INT_W+1 bits.
   localparam logic [INT_W:0] SPOS_LIM = {2'b00, {(INT_W-1){1'b1}}};
   localparam logic [INT_W:0] SNEG_LIM = {2'b01, {(INT_W-1){1'b0}}};

   logic             inc;
   logic             in_range;
   logic             sat;
   logic             sat_neg;
   logic [INT_W:0]   mag;
   logic [INT_W-1:0] mag_lo;

   always_comb begin
      case (rm_e'(rm))
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & (g | s);
         RM_RUP:  inc = ~sign & (g | s);
         RM_RMM:  inc = g;
         default: inc = g & (s | int_part[0]);
      endcase

      // One extra bit so a rounding carry out of the top is visible to the range check.
      mag    = {1'b0, int_part} + {{INT_W{1'b0}}, inc};
      mag_lo = mag[INT_W-1:0];

      if (is_signed) begin
         in_range = sign ? (mag <= SNEG_LIM) : (mag <= SPOS_LIM);
      end else begin
         // A negative operand is only legal for an unsigned target when it rounds to zero.
         in_range = sign ? (mag == '0) : ~mag[INT_W];
      end

      sat     = is_nan | is_inf | pre_ovf | ~in_range;
      // NaN always saturates towards the positive limit regardless of its sign bit.
      sat_neg = sign & ~is_nan;

      data = '0;
      nv   = 1'b0;
      nx   = 1'b0;
      if (is_zero) begin
         data = '0;
      end else if (sat) begin
         nv = 1'b1;
         if (is_signed) begin
            data = sat_neg ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
         end else begin
            data = sat_neg ? '0 : '1;
         end
      end else begin
         data = sign ? -mag_lo : mag_lo;
         nx   = g | s;
      end
   end

endmodule

// File: rtl/fp_to_int_conv.sv
// fp_to_int_conv: two-stage handshaked IEEE-754 float to integer converter.
//   S1 unpacks the operand, aligns the significand to an INT_W-bit integer part plus
//   guard/sticky, flags early overflow and classifies NaN/Inf/zero.
//   S2 (fp_round_sat) rounds, range-checks, saturates and raises NV/NX; its register
//   drives the outputs. Backpressure propagates combinationally, so full throughput
//   is kept with no bubbles.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   in_valid/in_ready                - operand handshake
//   in_a, in_signed, in_rm, in_tag   - float operand, target signedness, rounding mode, tag
//   out_valid/out_ready              - result handshake
//   out_data, out_nv, out_nx, out_tag - integer result, invalid, inexact, tag
module fp_to_int_conv
   import fpu_conv_pkg::*;
#(
   parameter int  EXP_W = 8,
   parameter int  MAN_W = 23,
   parameter int  INT_W = 32,
   parameter int  TAG_W = 5,
   localparam int FLEN  = flen_f(EXP_W, MAN_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [FLEN-1:0]  in_a,
   input  logic             in_signed,
   input  logic [2:0]       in_rm,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [INT_W-1:0] out_data,
   output logic             out_nv,
   output logic             out_nx,
   output logic [TAG_W-1:0] out_tag
);

   localparam int                    BIAS   = bias_f(EXP_W);
   localparam int                    XW     = 2*MAN_W + 3;
   localparam logic signed [EXP_W:0] BIAS_S = (EXP_W+1)'(BIAS);

   // ---------------- S1 combinational: unpack and align ----------------
   logic                  a_sign;
   logic [EXP_W-1:0]      a_exp;
   logic [EXP_W-1:0]      exp_eff;
   logic [MAN_W-1:0]      a_man;
   logic [MAN_W:0]        sig;
   logic signed [EXP_W:0] e_s;
   int                    e_i;
   int                    rsh;
   logic [XW-1:0]         shifted;
   logic [INT_W-1:0]      int_c;
   logic                  g_c;
   logic                  s_c;
   logic                  ovf_c;
   fclass_t               cls_c;

   always_comb begin
      a_sign  = in_a[FLEN-1];
      a_exp   = in_a[FLEN-2 -: EXP_W];
      a_man   = in_a[MAN_W-1:0];
      sig     = {(a_exp != '0), a_man};
      // Subnormals share the exponent of the smallest normal.
      exp_eff = (a_exp == '0) ? EXP_W'(1) : a_exp;
      e_s     = $signed({1'b0, exp_eff}) - BIAS_S;
      e_i     = int'(e_s);
      rsh     = MAN_W - e_i;

      shifted = '0;
      int_c   = '0;
      g_c     = 1'b0;
      s_c     = 1'b0;
      if (e_i >= MAN_W) begin
         // Exact integer; anything that would spill past INT_W bits is caught by ovf_c.
         int_c = INT_W'(sig) << (e_i - MAN_W);
      end else if (rsh > MAN_W + 2) begin
         s_c = |sig;
      end else begin
         // Fraction field holds MAN_W+2 bits so G and S fall out of fixed positions.
         shifted = {sig, {(MAN_W+2){1'b0}}} >> rsh;
         int_c   = INT_W'(shifted[XW-1 -: MAN_W+1]);
         g_c     = shifted[MAN_W+1];
         s_c     = |shifted[MAN_W:0];
      end

      ovf_c         = (e_i >= INT_W);
      cls_c.is_nan  = (a_exp == '1) && (a_man != '0);
      cls_c.is_inf  = (a_exp == '1) && (a_man == '0);
      cls_c.is_zero = (a_exp == '0) && (a_man == '0);
   end

   // ---------------- pipeline control ----------------
   logic             s1_valid_reg;
   logic             s2_valid_reg;
   logic             s1_adv;
   logic             s2_adv;

   assign s2_adv   = ~s2_valid_reg | out_ready;
   assign s1_adv   = ~s1_valid_reg | s2_adv;
   assign in_ready = s1_adv;

   // ---------------- S1 register ----------------
   logic             s1_sign_reg;
   logic [INT_W-1:0] s1_int_reg;
   logic             s1_g_reg;
   logic             s1_s_reg;
   logic             s1_ovf_reg;
   fclass_t          s1_cls_reg;
   logic             s1_signed_reg;
   logic [2:0]       s1_rm_reg;
   logic [TAG_W-1:0] s1_tag_reg;

   // ---------------- S2 combinational: round / saturate ----------------
   logic [INT_W-1:0] rs_data;
   logic             rs_nv;
   logic             rs_nx;

   fp_round_sat #(
      .INT_W (INT_W)
   ) u_round_sat (
      .sign      (s1_sign_reg),
      .int_part  (s1_int_reg),
      .g         (s1_g_reg),
      .s         (s1_s_reg),
      .pre_ovf   (s1_ovf_reg),
      .is_nan    (s1_cls_reg.is_nan),
      .is_inf    (s1_cls_reg.is_inf),
      .is_zero   (s1_cls_reg.is_zero),
      .is_signed (s1_signed_reg),
      .rm        (s1_rm_reg),
      .data      (rs_data),
      .nv        (rs_nv),
      .nx        (rs_nx)
   );

   // ---------------- S2 register (outputs) ----------------
   logic [INT_W-1:0] out_data_reg;
   logic             out_nv_reg;
   logic             out_nx_reg;
   logic [TAG_W-1:0] out_tag_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s1_sign_reg   <= 1'b0;
         s1_int_reg    <= '0;
         s1_g_reg      <= 1'b0;
         s1_s_reg      <= 1'b0;
         s1_ovf_reg    <= 1'b0;
         s1_cls_reg    <= '0;
         s1_signed_reg <= 1'b0;
         s1_rm_reg     <= '0;
         s1_tag_reg    <= '0;
         s2_valid_reg  <= 1'b0;
         out_data_reg  <= '0;
         out_nv_reg    <= 1'b0;
         out_nx_reg    <= 1'b0;
         out_tag_reg   <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
               s1_sign_reg   <= a_sign;
               s1_int_reg    <= int_c;
               s1_g_reg      <= g_c;
               s1_s_reg      <= s_c;
               s1_ovf_reg    <= ovf_c;
               s1_cls_reg    <= cls_c;
               s1_signed_reg <= in_signed;
               s1_rm_reg     <= in_rm;
               s1_tag_reg    <= in_tag;
            end
         end
         // Payload only loads on a real transfer, so it holds while stalled.
         if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
               out_data_reg <= rs_data;
               out_nv_reg   <= rs_nv;
               out_nx_reg   <= rs_nx;
               out_tag_reg  <= s1_tag_reg;
            end
         end
      end
   end

   assign out_valid = s2_valid_reg;
   assign out_data  = out_data_reg;
   assign out_nv    = out_nv_reg;
   assign out_nx    = out_nx_reg;
   assign out_tag   = out_tag_reg;

endmodule
